// File: rtl/register_scoreboard.sv
// rtl/register_scoreboard.sv - in-order register write scoreboard driving the decode stall
// Optional SCOREBOARD_STATS_EN adds the stallCycles counter output.
module register_scoreboard #(
  parameter int MAX_INFLIGHT = 3
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        issueValid,
  input  logic        issueWriteEnable,
  input  logic        issueIsLoad,
  input  logic [4:0]  issueDestinationRegister,
  input  logic        issueUses1,
  input  logic        issueUses2,
  input  logic [4:0]  issueRegister1,
  input  logic [4:0]  issueRegister2,
  input  logic        retireValid,
  input  logic        retireWasLoad,
  input  logic [4:0]  retireDestinationRegister,
  input  logic        killValid,
  input  logic        killWasLoad,
  input  logic [4:0]  killDestinationRegister,
  input  logic        flushAll,
  output logic        stall,
  output logic [31:0] busyMask,
`ifdef SCOREBOARD_STATS_EN
  output logic [31:0] stallCycles,
`endif
  output logic        underflowError
);

  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam int EW = CW + 2;
  localparam logic [CW-1:0] CMAX = CW'(MAX_INFLIGHT);

  logic [CW-1:0] pendingCount [32];
  logic [CW-1:0] loadCount    [32];
  logic [CW-1:0] effPend      [32];
  logic [CW-1:0] effLoad      [32];
  logic [CW-1:0] pendNext     [32];
  logic [CW-1:0] loadNext     [32];
  logic [1:0]    decP         [32];
  logic [1:0]    decL         [32];
  logic          underflowNext;
  logic          accept;

  // Retire bypass: a same-cycle retire/kill already frees its slot; clamp at 0 on underflow.
  always_comb begin
    for (int r = 0; r < 32; r++) begin
      logic retHit;
      logic killHit;
      retHit  = retireValid && (retireDestinationRegister == 5'(r)) && (r != 0);
      killHit = killValid && (killDestinationRegister == 5'(r)) && (r != 0);
      decP[r] = {1'b0, retHit} + {1'b0, killHit};
      decL[r] = {1'b0, retHit && retireWasLoad} + {1'b0, killHit && killWasLoad};
      effPend[r] = (EW'(decP[r]) > EW'(pendingCount[r])) ? '0 : pendingCount[r] - CW'(decP[r]);
      effLoad[r] = (EW'(decL[r]) > EW'(loadCount[r])) ? '0 : loadCount[r] - CW'(decL[r]);
    end
  end

  always_comb begin
    stall = 1'b0;
    if (issueValid) begin
      if (issueUses1 && (effLoad[issueRegister1] != '0)) stall = 1'b1;
      if (issueUses2 && (effLoad[issueRegister2] != '0)) stall = 1'b1;
      if (issueWriteEnable && (effPend[issueDestinationRegister] == CMAX)) stall = 1'b1;
    end
  end

  assign accept = issueValid && !stall && issueWriteEnable && (issueDestinationRegister != 5'd0);

  always_comb begin
    underflowNext = 1'b0;
    for (int r = 0; r < 32; r++) begin
      logic hit;
      hit = accept && (issueDestinationRegister == 5'(r));
      pendNext[r] = effPend[r] + CW'(hit);
      loadNext[r] = effLoad[r] + CW'(hit && issueIsLoad);
      if ((EW'(decP[r]) > EW'(pendingCount[r])) || (EW'(decL[r]) > EW'(loadCount[r])))
        underflowNext = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int r = 0; r < 32; r++) begin
        pendingCount[r] <= '0;
        loadCount[r]    <= '0;
      end
      underflowError <= 1'b0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        pendingCount[r] <= flushAll ? '0 : pendNext[r];
        loadCount[r]    <= flushAll ? '0 : loadNext[r];
      end
      if (!flushAll && underflowNext) underflowError <= 1'b1;
    end
  end

  always_comb begin
    busyMask = '0;
    for (int r = 1; r < 32; r++) busyMask[r] = (pendingCount[r] != '0);
  end

`ifdef SCOREBOARD_STATS_EN
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) stallCycles <= '0;
    else if (flushAll) stallCycles <= '0;
    else if (stall) stallCycles <= stallCycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_register_scoreboard.sv
// tb/tb_register_scoreboard.sv - directed self-checking bench for register_scoreboard
module tb_register_scoreboard;

  logic        clock = 1'b0;
  logic        resetN;
  logic        issueValid, issueWriteEnable, issueIsLoad, issueUses1, issueUses2;
  logic [4:0]  issueDestinationRegister, issueRegister1, issueRegister2;
  logic        retireValid, retireWasLoad, killValid, killWasLoad, flushAll;
  logic [4:0]  retireDestinationRegister, killDestinationRegister;
  logic        stall, underflowError;
  logic [31:0] busyMask;
`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stallCycles;
`endif

  int total = 0;
  int bad = 0;

  register_scoreboard #(.MAX_INFLIGHT(3)) dut (
    .clock(clock), .resetN(resetN),
    .issueValid(issueValid), .issueWriteEnable(issueWriteEnable), .issueIsLoad(issueIsLoad),
    .issueDestinationRegister(issueDestinationRegister),
    .issueUses1(issueUses1), .issueUses2(issueUses2),
    .issueRegister1(issueRegister1), .issueRegister2(issueRegister2),
    .retireValid(retireValid), .retireWasLoad(retireWasLoad),
    .retireDestinationRegister(retireDestinationRegister),
    .killValid(killValid), .killWasLoad(killWasLoad),
    .killDestinationRegister(killDestinationRegister),
    .flushAll(flushAll), .stall(stall), .busyMask(busyMask),
`ifdef SCOREBOARD_STATS_EN
    .stallCycles(stallCycles),
`endif
    .underflowError(underflowError)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    issueValid = 0; issueWriteEnable = 0; issueIsLoad = 0; issueUses1 = 0; issueUses2 = 0;
    issueDestinationRegister = 0; issueRegister1 = 0; issueRegister2 = 0;
    retireValid = 0; retireWasLoad = 0; retireDestinationRegister = 0;
    killValid = 0; killWasLoad = 0; killDestinationRegister = 0; flushAll = 0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    idle();
    #1;
  endtask

  task automatic issue_w(input logic [4:0] rd, input logic ld);
    issueValid = 1; issueWriteEnable = 1; issueIsLoad = ld; issueDestinationRegister = rd;
    #1;
  endtask

  task automatic issue_use1(input logic [4:0] rs, input logic [4:0] rd, input logic we);
    issueValid = 1; issueUses1 = 1; issueRegister1 = rs;
    issueWriteEnable = we; issueDestinationRegister = rd;
    #1;
  endtask

  task automatic retire(input logic [4:0] rd, input logic ld);
    retireValid = 1; retireWasLoad = ld; retireDestinationRegister = rd;
    #1;
  endtask

  initial begin
    idle();
    resetN = 0;
    #12;
    check("reset_busy", busyMask, 32'h0);
    check("reset_uf", {31'b0, underflowError}, 32'h0);
    check("reset_stall", {31'b0, stall}, 32'h0);
    resetN = 1;
    step();

    // load-use hazard on x5
    issue_w(5'd5, 1'b1);
    check("ld_issue_stall", {31'b0, stall}, 32'h0);
    step();
    check("ld_busy", busyMask, 32'h0000_0020);
    issue_use1(5'd5, 5'd6, 1'b1);
    check("ld_use_c1", {31'b0, stall}, 32'h1);
    step();
    issue_use1(5'd5, 5'd6, 1'b1);
    check("ld_use_c2", {31'b0, stall}, 32'h1);
    step();
    issue_use1(5'd5, 5'd6, 1'b1);
    retire(5'd5, 1'b1);
    check("ld_use_bypass", {31'b0, stall}, 32'h0);
    step();
    check("ld_add_accepted", busyMask, 32'h0000_0040);
    retire(5'd6, 1'b0);
    step();
    check("ld_clean", busyMask, 32'h0);

    // x0 is never tracked
    issue_w(5'd0, 1'b1);
    step();
    retire(5'd0, 1'b1);
    step();
    check("x0_busy", busyMask, 32'h0);
    check("x0_no_uf", {31'b0, underflowError}, 32'h0);

    // ALU producer does not stall a consumer
    issue_w(5'd7, 1'b0);
    step();
    issue_use1(5'd7, 5'd0, 1'b0);
    check("alu_no_stall", {31'b0, stall}, 32'h0);
    step();
    check("alu_busy", busyMask, 32'h0000_0080);
    retire(5'd7, 1'b0);
    step();
    check("alu_cleared", busyMask, 32'h0);

    // saturation of x9
    for (int i = 0; i < 3; i++) begin
      issue_w(5'd9, 1'b0);
      check($sformatf("sat_w%0d", i), {31'b0, stall}, 32'h0);
      step();
    end
    issue_w(5'd9, 1'b0);
    check("sat_stall", {31'b0, stall}, 32'h1);
    retire(5'd9, 1'b0);
    check("sat_bypass", {31'b0, stall}, 32'h0);
    step();
    issue_w(5'd9, 1'b0);
    check("sat_still3", {31'b0, stall}, 32'h1);
    idle();
    for (int i = 0; i < 3; i++) begin
      retire(5'd9, 1'b0);
      step();
    end
    check("sat_drained", busyMask, 32'h0);
    check("sat_no_uf", {31'b0, underflowError}, 32'h0);

    // issue + retire + kill on x4 from count 2
    issue_w(5'd4, 1'b0);
    step();
    issue_w(5'd4, 1'b0);
    step();
    issue_w(5'd4, 1'b0);
    retire(5'd4, 1'b0);
    killValid = 1; killWasLoad = 0; killDestinationRegister = 5'd4;
    #1;
    check("net_stall", {31'b0, stall}, 32'h0);
    step();
    check("net_busy", busyMask, 32'h0000_0010);
    retire(5'd4, 1'b0);
    step();
    check("net_count1", busyMask, 32'h0);
    check("net_no_uf", {31'b0, underflowError}, 32'h0);
    retire(5'd4, 1'b0);
    step();
    check("uf_set", {31'b0, underflowError}, 32'h1);
    step();
    check("uf_sticky", {31'b0, underflowError}, 32'h1);

    // flush with every register busy
    for (int r = 1; r < 32; r++) begin
      issue_w(5'(r), (r == 10));
      step();
    end
    check("all_busy", busyMask, 32'hFFFF_FFFE);
    issue_use1(5'd10, 5'd2, 1'b1);
    flushAll = 1;
    #1;
    check("flush_prestate_stall", {31'b0, stall}, 32'h1);
    step();
    check("flush_busy", busyMask, 32'h0);

`ifdef SCOREBOARD_STATS_EN
    check("stats_flushed", stallCycles, 32'h0);
    issue_w(5'd12, 1'b1);
    step();
    for (int i = 0; i < 4; i++) begin
      issue_use1(5'd12, 5'd0, 1'b0);
      step();
    end
    check("stats_four", stallCycles, 32'd4);
    flushAll = 1;
    #1;
    step();
    check("stats_zero", stallCycles, 32'h0);
`endif

    // asynchronous reset mid-stall
    issue_w(5'd11, 1'b1);
    step();
    issue_use1(5'd11, 5'd0, 1'b0);
    check("pre_reset_stall", {31'b0, stall}, 32'h1);
    #1;
    resetN = 0;
    #1;
    check("async_stall", {31'b0, stall}, 32'h0);
    check("async_busy", busyMask, 32'h0);
    check("async_uf", {31'b0, underflowError}, 32'h0);
    step();
    resetN = 1;
    step();
    issue_use1(5'd11, 5'd0, 1'b0);
    check("post_reset_empty", {31'b0, stall}, 32'h0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
